// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: hold, debounce PLL lock, then release
// each downstream reset domain in index order.
module reset_seq_ctrl #(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_LEN    = 63,
   parameter int LOCK_FILTER = 7,
   parameter int STAGE_LEN   = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pll_locked,
   input  logic                   soft_req,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic                   ready,
   output logic [1:0]             state_o
);

   localparam int M1 = (HOLD_LEN > LOCK_FILTER) ? HOLD_LEN : LOCK_FILTER;
   localparam int MX = (M1 > STAGE_LEN) ? M1 : STAGE_LEN;
   localparam int CW = $clog2(MX + 1);
   localparam int IW = $clog2(NUM_DOMAINS) + 1;

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_LOCK  = 2'd1,
      S_STAGE = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [IW-1:0]          idx, idx_n;
   logic [NUM_DOMAINS-1:0] rst_n_n;
   logic                   ready_n;
   logic                   lock_m, lock_s;
   logic                   abort;

   // Plain 2-flop synchronizer, deliberately unreset
   always_ff @(posedge clk) begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
   end

   assign abort = soft_req |
                  (~lock_s & ((state == S_STAGE) | (state == S_RUN)));

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      rst_n_n = rst_n_out;
      ready_n = ready;
      unique case (state)
         S_HOLD: begin
            if (cnt == CW'(HOLD_LEN)) begin
               state_n = S_LOCK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_LOCK: begin
            if (lock_s) begin
               if (cnt == CW'(LOCK_FILTER)) begin
                  state_n = S_STAGE;
                  cnt_n   = '0;
                  idx_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end else begin
               cnt_n = '0;
            end
         end
         S_STAGE: begin
            if (cnt == CW'(STAGE_LEN)) begin
               cnt_n = '0;
               idx_n = idx + IW'(1);
               for (int i = 0; i < NUM_DOMAINS; i++)
                  if (idx == IW'(i)) rst_n_n[i] = 1'b1;
               if (idx == IW'(NUM_DOMAINS - 1)) begin
                  state_n = S_RUN;
                  ready_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_RUN: begin
         end
      endcase
      // Abort overrides any release scheduled on this edge
      if (abort && state != S_HOLD) begin
         state_n = S_HOLD;
         cnt_n   = '0;
         idx_n   = '0;
         rst_n_n = '0;
         ready_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HOLD;
         cnt       <= '0;
         idx       <= '0;
         rst_n_out <= '0;
         ready     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         rst_n_out <= rst_n_n;
         ready     <= ready_n;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl; edge numbers count from
// the first edge with reset sampled low.
module tb_reset_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_locked;
   logic       soft_req;
   logic [2:0] rst_n_out;
   logic       ready;
   logic [1:0] state_o;

   int n_vec = 0;
   int n_bad = 0;
   int e;

   reset_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .pll_locked (pll_locked),
      .soft_req   (soft_req),
      .rst_n_out  (rst_n_out),
      .ready      (ready),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0h expected %0h",
                  tag, e, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic go(input int k);
      while (e < k) tick();
   endtask

   task automatic outs(input string tag, input logic [1:0] st,
                       input logic [2:0] r, input logic rdy);
      chk({tag, "_st"},  32'(state_o),   32'(st));
      chk({tag, "_rst"}, 32'(rst_n_out), 32'(r));
      chk({tag, "_rdy"}, 32'(ready),     32'(rdy));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      outs("rst", 2'd0, 3'b000, 1'b0);
      reset = 1'b0;
      e = -1;
   endtask

   // Thermometer and ready/state consistency on every cycle
   logic [2:0] t1;
   always @(negedge clk) begin
      t1 = rst_n_out + 3'd1;
      chk("thermo", 32'((t1 & rst_n_out) == 3'b000), 32'd1);
      chk("rdy_all", 32'(ready), 32'(&rst_n_out));
      chk("rdy_run", 32'(ready), 32'(state_o == 2'd3));
   end

   initial begin
      e = 0;
      soft_req   = 1'b0;
      pll_locked = 1'b1;

      // Cold start, lock stable
      do_reset();
      go(62);  outs("c62",  2'd0, 3'b000, 1'b0);
      go(63);  outs("c63",  2'd1, 3'b000, 1'b0);
      go(70);  outs("c70",  2'd1, 3'b000, 1'b0);
      go(71);  outs("c71",  2'd2, 3'b000, 1'b0);
      go(86);  outs("c86",  2'd2, 3'b000, 1'b0);
      go(87);  outs("c87",  2'd2, 3'b001, 1'b0);
      go(102); outs("c102", 2'd2, 3'b001, 1'b0);
      go(103); outs("c103", 2'd2, 3'b011, 1'b0);
      go(118); outs("c118", 2'd2, 3'b011, 1'b0);
      go(119); outs("c119", 2'd3, 3'b111, 1'b1);

      // Lock loss in S_RUN, then replay
      go(130); pll_locked = 1'b0;
      go(132); outs("l132", 2'd3, 3'b111, 1'b1);
      go(133); outs("l133", 2'd0, 3'b000, 1'b0);
      pll_locked = 1'b1;
      go(220); outs("l220", 2'd2, 3'b000, 1'b0);
      go(221); outs("l221", 2'd2, 3'b001, 1'b0);
      go(252); outs("l252", 2'd2, 3'b011, 1'b0);
      go(253); outs("l253", 2'd3, 3'b111, 1'b1);

      // Late lock: wait in S_LOCK
      pll_locked = 1'b0;
      do_reset();
      go(199); outs("w199", 2'd1, 3'b000, 1'b0);
      go(200); pll_locked = 1'b1;
      go(209); outs("w209", 2'd1, 3'b000, 1'b0);
      go(210); outs("w210", 2'd2, 3'b000, 1'b0);
      go(225); outs("w225", 2'd2, 3'b000, 1'b0);
      go(226); outs("w226", 2'd2, 3'b001, 1'b0);

      // Lock glitch restarts the filter
      pll_locked = 1'b0;
      do_reset();
      go(100); pll_locked = 1'b1;
      go(105); pll_locked = 1'b0;
      go(106); pll_locked = 1'b1;
      go(110); outs("g110", 2'd1, 3'b000, 1'b0);
      go(115); outs("g115", 2'd1, 3'b000, 1'b0);
      go(116); outs("g116", 2'd2, 3'b000, 1'b0);
      go(131); outs("g131", 2'd2, 3'b000, 1'b0);
      go(132); outs("g132", 2'd2, 3'b001, 1'b0);

      // Soft pulse in S_STAGE aborts; pulse in S_HOLD is ignored
      do_reset();
      go(90);  outs("s90", 2'd2, 3'b001, 1'b0);
      soft_req = 1'b1;
      go(91);  outs("s91", 2'd0, 3'b000, 1'b0);
      soft_req = 1'b0;
      go(99);  soft_req = 1'b1;
      go(100); soft_req = 1'b0;
      go(154); outs("s154", 2'd0, 3'b000, 1'b0);
      go(155); outs("s155", 2'd1, 3'b000, 1'b0);
      go(178); outs("s178", 2'd2, 3'b000, 1'b0);
      go(179); outs("s179", 2'd2, 3'b001, 1'b0);

      // Soft request held in S_LOCK keeps re-aborting
      go(200); soft_req = 1'b1;
      go(201); outs("h201", 2'd0, 3'b000, 1'b0);
      go(265); outs("h265", 2'd1, 3'b000, 1'b0);
      go(266); outs("h266", 2'd0, 3'b000, 1'b0);
      soft_req = 1'b0;

      // Reset mid-S_STAGE, then a clean cold-start replay
      do_reset();
      go(100); outs("r100", 2'd2, 3'b001, 1'b0);
      reset = 1'b1;
      go(101); outs("r101", 2'd0, 3'b000, 1'b0);
      do_reset();
      go(86);  outs("q86",  2'd2, 3'b000, 1'b0);
      go(87);  outs("q87",  2'd2, 3'b001, 1'b0);
      go(95);  reset = 1'b1; soft_req = 1'b1;
      go(96);  outs("q96",  2'd0, 3'b000, 1'b0);
      soft_req = 1'b0;
      do_reset();
      go(87);  outs("x87",  2'd2, 3'b001, 1'b0);
      go(103); outs("x103", 2'd2, 3'b011, 1'b0);
      go(119); outs("x119", 2'd3, 3'b111, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
